// File: rtl/rvv_hold_ctrl.sv
// rvv_hold_ctrl
//   Pipeline hold/flush controller for the vector core. It merges hold
//   requests from NREQ requesters, plus a bus hold, into per-stage holds
//   for NSTAGE stages. Stage 0 is the youngest stage and stage NSTAGE-1
//   is the oldest. The block also contains a flush sequencer, a hold
//   watchdog and a saturating stall counter for each stage.
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rstn           synchronous, active-low reset
//   hold_req_i     per-requester hold requests; bit r*NSTAGE+s is requester r, stage s
//   req_en_i       per-requester enable
//   ext_hold_i     bus hold; applied to the stages set in EXT_MASK
//   flush_req_i    single-cycle flush request pulse
//   flush_stage_i  flush origin s; stages 0..s-1 are flushed
//   hold_o         per-stage hold (combinational)
//   flush_o        per-stage flush (driven only from registers)
//   busy_o         high while a flush sequence is active
//   timeout_o      sticky watchdog error flag
//   clr_timeout_i  clears timeout_o and the watchdog counter
//   stall_sel_i    selects which stall counter is read
//   stall_clr_i    clears all stall counters
//   stall_cnt_o    stall counter of the selected stage (combinational mux)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no flush in progress; hold_o follows the raw hold
// FLUSH | flush_o drives the latched mask; flushed stages are not held
module rvv_hold_ctrl #(
    parameter int                NSTAGE    = 4,
    parameter int                NREQ      = 2,
    parameter logic [NSTAGE-1:0] EXT_MASK  = NSTAGE'(4'b0011),
    parameter int                PROPAGATE = 1,
    parameter int                FLUSH_CYC = 2,
    parameter int                TIMEOUT   = 1024,
    parameter int                STALL_W   = 16,
    parameter int                SW        = $clog2(NSTAGE)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ*NSTAGE-1:0] hold_req_i,
    input  logic [NREQ-1:0]        req_en_i,
    input  logic                   ext_hold_i,
    input  logic                   flush_req_i,
    input  logic [SW-1:0]          flush_stage_i,
    output logic [NSTAGE-1:0]      hold_o,
    output logic [NSTAGE-1:0]      flush_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    input  logic                   clr_timeout_i,
    input  logic [SW-1:0]          stall_sel_i,
    input  logic                   stall_clr_i,
    output logic [STALL_W-1:0]     stall_cnt_o
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    logic               state_q, state_d;
    logic [SW-1:0]      fs_q, fs_d;
    logic [3:0]         fcnt_q, fcnt_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               timeout_q, timeout_d;
    logic [STALL_W-1:0] stall_q [NSTAGE];
    logic [STALL_W-1:0] stall_d [NSTAGE];

    logic [NSTAGE-1:0]  req;
    logic [NSTAGE-1:0]  raw;
    logic [NSTAGE-1:0]  fmask;
    logic               accept;

    // Effective request per stage, then raw hold. With propagation a hold
    // on an older stage also stalls everything younger behind it.
    always_comb begin
        logic acc;
        req = '0;
        raw = '0;
        acc = 1'b0;
        for (int s = 0; s < NSTAGE; s++) begin
            for (int r = 0; r < NREQ; r++) begin
                req[s] = req[s] | (req_en_i[r] & hold_req_i[r*NSTAGE+s]);
            end
            req[s] = req[s] | (ext_hold_i & EXT_MASK[s]);
        end
        if (PROPAGATE != 0) begin
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                acc    = acc | req[s];
                raw[s] = acc;
            end
        end else begin
            raw = req;
        end
    end

    always_comb begin
        fmask = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            fmask[s] = (s < int'(fs_q));
        end
    end

    always_comb begin
        if (!rstn) begin
            hold_o = '0;
        end else if (state_q == ST_FLUSH) begin
            hold_o = raw & ~fmask;
        end else begin
            hold_o = raw;
        end
    end

    assign flush_o   = (state_q == ST_FLUSH) ? fmask : '0;
    assign busy_o    = (state_q == ST_FLUSH);
    assign timeout_o = timeout_q;

    // Origin 0 flushes nothing and is dropped; mid-sequence only an older
    // origin (larger mask) restarts the window.
    assign accept = flush_req_i && (flush_stage_i != '0) &&
                    ((state_q == ST_IDLE) || (flush_stage_i > fs_q));

    always_comb begin
        state_d = state_q;
        fs_d    = fs_q;
        fcnt_d  = fcnt_q;
        if (accept) begin
            state_d = ST_FLUSH;
            fs_d    = flush_stage_i;
            fcnt_d  = 4'(FLUSH_CYC - 1);
        end else if (state_q == ST_FLUSH) begin
            if (fcnt_q == 4'd0) begin
                state_d = ST_IDLE;
            end else begin
                fcnt_d = fcnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (clr_timeout_i) begin
            wd_d      = '0;
            timeout_d = 1'b0;
        end else begin
            if (hold_o == '0) begin
                wd_d = '0;
            end else if (wd_q != WDW'(TIMEOUT)) begin
                wd_d = wd_q + 1'b1;
            end
            if (wd_d == WDW'(TIMEOUT)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NSTAGE; s++) begin
            stall_d[s] = stall_q[s];
            if (stall_clr_i) begin
                stall_d[s] = '0;
            end else if (hold_o[s] && (stall_q[s] != '1)) begin
                stall_d[s] = stall_q[s] + 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        if (rstn && (int'(stall_sel_i) < NSTAGE)) begin
            stall_cnt_o = stall_q[stall_sel_i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            fs_q      <= '0;
            fcnt_q    <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            for (int s = 0; s < NSTAGE; s++) begin
                stall_q[s] <= '0;
            end
        end else begin
            state_q   <= state_d;
            fs_q      <= fs_d;
            fcnt_q    <= fcnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            for (int s = 0; s < NSTAGE; s++) begin
                stall_q[s] <= stall_d[s];
            end
        end
    end

endmodule

// File: tb/tb_rvv_hold_ctrl.sv
module tb_rvv_hold_ctrl;

    logic       clk;
    logic       rstn;
    logic [7:0] hold_req_i;
    logic [1:0] req_en_i;
    logic       ext_hold_i;
    logic       flush_req_i;
    logic [1:0] flush_stage_i;
    logic       clr_timeout_i;
    logic [1:0] stall_sel_i;
    logic       stall_clr_i;

    logic [3:0] hold_o,  flush_o;
    logic       busy_o,  timeout_o;
    logic [3:0] stall_cnt_o;
    logic [3:0] hold1_o, flush1_o;
    logic       busy1_o, timeout1_o;
    logic [3:0] stall1_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    rvv_hold_ctrl #(
        .NSTAGE(4), .NREQ(2), .EXT_MASK(4'b0011), .PROPAGATE(1),
        .FLUSH_CYC(2), .TIMEOUT(8), .STALL_W(4)
    ) dut (
        .clk(clk), .rstn(rstn), .hold_req_i(hold_req_i), .req_en_i(req_en_i),
        .ext_hold_i(ext_hold_i), .flush_req_i(flush_req_i),
        .flush_stage_i(flush_stage_i), .hold_o(hold_o), .flush_o(flush_o),
        .busy_o(busy_o), .timeout_o(timeout_o), .clr_timeout_i(clr_timeout_i),
        .stall_sel_i(stall_sel_i), .stall_clr_i(stall_clr_i),
        .stall_cnt_o(stall_cnt_o)
    );

    rvv_hold_ctrl #(
        .NSTAGE(4), .NREQ(2), .EXT_MASK(4'b0011), .PROPAGATE(0),
        .FLUSH_CYC(2), .TIMEOUT(8), .STALL_W(4)
    ) dut_np (
        .clk(clk), .rstn(rstn), .hold_req_i(hold_req_i), .req_en_i(req_en_i),
        .ext_hold_i(ext_hold_i), .flush_req_i(flush_req_i),
        .flush_stage_i(flush_stage_i), .hold_o(hold1_o), .flush_o(flush1_o),
        .busy_o(busy1_o), .timeout_o(timeout1_o), .clr_timeout_i(clr_timeout_i),
        .stall_sel_i(stall_sel_i), .stall_clr_i(stall_clr_i),
        .stall_cnt_o(stall1_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rstn          = 1'b0;
        hold_req_i    = 8'hFF;
        req_en_i      = 2'b11;
        ext_hold_i    = 1'b1;
        flush_req_i   = 1'b0;
        flush_stage_i = 2'd0;
        clr_timeout_i = 1'b0;
        stall_sel_i   = 2'd0;
        stall_clr_i   = 1'b0;
        ticks(2);
        #2;
        check("rst_hold",    hold_o,      4'h0);
        check("rst_hold_np", hold1_o,     4'h0);
        check("rst_flush",   flush_o,     4'h0);
        check("rst_busy",    busy_o,      1'b0);
        check("rst_timeout", timeout_o,   1'b0);
        check("rst_stall",   stall_cnt_o, 4'h0);

        rstn       = 1'b1;
        hold_req_i = 8'h00;
        ext_hold_i = 1'b0;
        tick();

        // Combinational merge, all within one cycle.
        hold_req_i = 8'b0100_0000; #2;
        check("prop_req1_s2",  hold_o,  4'b0111);
        check("noprop_req1_s2", hold1_o, 4'b0100);
        req_en_i = 2'b01; #2;
        check("prop_req1_off", hold_o, 4'b0000);
        req_en_i = 2'b11; hold_req_i = 8'h00; ext_hold_i = 1'b1; #2;
        check("ext_prop",   hold_o,  4'b0011);
        check("ext_noprop", hold1_o, 4'b0011);
        ext_hold_i = 1'b0; hold_req_i = 8'b0000_1000; #2;
        check("s3_noprop", hold1_o, 4'b1000);
        check("s3_prop",   hold_o,  4'b1111);
        hold_req_i = 8'h00;
        tick();

        // Flush origin 3 while stage 1 is held.
        hold_req_i    = 8'b0000_0010;
        flush_req_i   = 1'b1;
        flush_stage_i = 2'd3; #2;
        check("fl_req_hold", hold_o, 4'b0011);
        check("fl_req_busy", busy_o, 1'b0);
        tick();
        flush_req_i = 1'b0; #2;
        check("fl_t1_flush", flush_o, 4'b0111);
        check("fl_t1_busy",  busy_o,  1'b1);
        check("fl_t1_hold",  hold_o,  4'b0000);
        tick(); #2;
        check("fl_t2_flush", flush_o, 4'b0111);
        check("fl_t2_busy",  busy_o,  1'b1);
        check("fl_t2_hold",  hold_o,  4'b0000);
        tick(); #2;
        check("fl_t3_flush", flush_o, 4'b0000);
        check("fl_t3_busy",  busy_o,  1'b0);
        check("fl_t3_hold",  hold_o,  4'b0011);
        hold_req_i    = 8'h00;
        flush_req_i   = 1'b1;
        flush_stage_i = 2'd0;
        tick();
        flush_req_i = 1'b0; #2;
        check("fl_s0_busy",  busy_o,  1'b0);
        check("fl_s0_flush", flush_o, 4'b0000);
        tick();

        // Origin 1, then older origin 3, then a younger origin 2 that is ignored.
        flush_req_i = 1'b1; flush_stage_i = 2'd1;
        tick();
        flush_stage_i = 2'd3; #2;
        check("re_t1_flush", flush_o, 4'b0001);
        tick();
        flush_stage_i = 2'd2; #2;
        check("re_t2_flush", flush_o, 4'b0111);
        tick();
        flush_req_i = 1'b0; #2;
        check("re_t3_flush", flush_o, 4'b0111);
        check("re_t3_busy",  busy_o,  1'b1);
        tick(); #2;
        check("re_t4_flush", flush_o, 4'b0000);
        check("re_t4_busy",  busy_o,  1'b0);

        // Watchdog.
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0; #2;
        check("wd_clr0", timeout_o, 1'b0);
        hold_req_i = 8'h01;
        ticks(7); #2;
        check("wd_c8", timeout_o, 1'b0);
        tick();
        hold_req_i = 8'h00; #2;
        check("wd_c9", timeout_o, 1'b1);
        tick(); #2;
        check("wd_sticky", timeout_o, 1'b1);
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0; #2;
        check("wd_clr1", timeout_o, 1'b0);
        hold_req_i = 8'h01;
        ticks(7);
        hold_req_i = 8'h00;
        tick();
        hold_req_i = 8'h01;
        ticks(7);
        hold_req_i = 8'h00;
        ticks(2); #2;
        check("wd_7_gap_7", timeout_o, 1'b0);

        // Stall counters.
        stall_clr_i = 1'b1;
        tick();
        stall_clr_i = 1'b0; #2;
        check("st_clr0", stall_cnt_o, 4'h0);
        hold_req_i = 8'h01;
        ticks(5); #2;
        check("st_s0_5", stall_cnt_o, 4'h5);
        stall_sel_i = 2'd1; #2;
        check("st_s1_5", stall_cnt_o, 4'h0);
        stall_sel_i = 2'd0;
        ticks(9); #2;
        check("st_s0_14", stall_cnt_o, 4'hE);
        ticks(6);
        hold_req_i = 8'h00; #2;
        check("st_s0_sat", stall_cnt_o, 4'hF);
        stall_clr_i = 1'b1;
        tick();
        stall_clr_i = 1'b0; #2;
        check("st_clr1", stall_cnt_o, 4'h0);

        // Reset in the middle of a flush.
        hold_req_i    = 8'h01;
        flush_req_i   = 1'b1;
        flush_stage_i = 2'd3;
        tick();
        flush_req_i = 1'b0; #2;
        check("mr_busy", busy_o, 1'b1);
        rstn = 1'b0; #2;
        check("mr_hold_comb", hold_o, 4'h0);
        tick(); #2;
        check("mr_flush",   flush_o,     4'h0);
        check("mr_busy0",   busy_o,      1'b0);
        check("mr_timeout", timeout_o,   1'b0);
        check("mr_stall",   stall_cnt_o, 4'h0);
        rstn = 1'b1;
        hold_req_i = 8'h00;
        tick(); #2;
        check("mr_stall_after", stall_cnt_o, 4'h0);
        check("mr_busy_after",  busy_o,      1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
